// File: rtl/modulus_acc_pkg.sv
// modulus_acc_pkg
//   Shared constants, FSM state type and helpers for the modulus LUT
//   accumulator (top: modulus_lut_accumulator, column: modulus_acc_column).
//   Values here are the default configuration; the modules carry their own
//   parameters so that other sizes can be built.
package modulus_acc_pkg;

  // Number of clock passes needed to consume all terms of one column.
  function automatic int num_passes(input int acc_elements, input int terms_per_cycle);
    return (acc_elements + terms_per_cycle - 1) / terms_per_cycle;
  endfunction

  localparam int DEF_BIT_LEN         = 51;
  localparam int DEF_ACC_ELEMENTS    = 173;
  localparam int DEF_TERMS_PER_CYCLE = 16;

  localparam int WORD_LEN   = DEF_BIT_LEN - 1;
  // Wide enough for ACC_ELEMENTS full-scale words plus a full-scale base.
  localparam int SUM_LEN    = WORD_LEN + $clog2(DEF_ACC_ELEMENTS + 2);
  localparam int NUM_PASSES = num_passes(DEF_ACC_ELEMENTS, DEF_TERMS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/modulus_acc_column.sv
// modulus_acc_column
//   One output column: sums TERMS_PER_CYCLE LUT words per clock into an
//   unsigned accumulator that is preloaded with the zero-extended base.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        preload accumulator with base (takes priority over en)
//   en          add this pass's terms to the accumulator
//   base        [BIT_LEN-1:0] starting value
//   terms       [TERMS_PER_CYCLE-1:0][WORD_LEN-1:0] this pass's words
//   acc_next    [SUM_LEN-1:0] accumulator value after this pass's add
module modulus_acc_column
  import modulus_acc_pkg::*;
#(
  parameter int BIT_LEN         = 51,
  parameter int WORD_LEN        = BIT_LEN - 1,
  parameter int TERMS_PER_CYCLE = 16,
  parameter int SUM_LEN         = WORD_LEN + 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     load,
  input  logic                                     en,
  input  logic [BIT_LEN-1:0]                       base,
  input  logic [TERMS_PER_CYCLE-1:0][WORD_LEN-1:0] terms,
  output logic [SUM_LEN-1:0]                       acc_next
);

  logic [SUM_LEN-1:0] pass_sum_p0;
  logic [SUM_LEN-1:0] acc_p1;

  // Stage p0: combinational adder tree over this pass's terms.
  always_comb begin
    pass_sum_p0 = '0;
    for (int k = 0; k < TERMS_PER_CYCLE; k++) begin
      pass_sum_p0 = pass_sum_p0 + SUM_LEN'(terms[k]);
    end
  end

  assign acc_next = acc_p1 + pass_sum_p0;

  // Stage p1: accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
    end else if (load) begin
      acc_p1 <= SUM_LEN'(base);
    end else if (en) begin
      acc_p1 <= acc_next;
    end
  end

endmodule

// File: rtl/modulus_lut_accumulator.sv
// modulus_lut_accumulator
//   Sums, per output element, all ACC_ELEMENTS reduction-LUT words plus a
//   base coefficient, TERMS_PER_CYCLE terms per clock, producing redundant
//   form sums for the next square iteration.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin accumulation (accepted in IDLE or DONE)
//   clear_err   clear the sticky overrun flag
//   base        [NUM_ELEMENTS-1:0][BIT_LEN-1:0] per-element start values
//   lut_datas   [NUM_ELEMENTS-1:0][ACC_ELEMENTS-1:0][WORD_LEN-1:0] words,
//               stable from start until done
//   busy        high while accumulating
//   done        one-cycle pulse, sums valid
//   sums        [NUM_ELEMENTS-1:0][SUM_LEN-1:0] results, held until next done
//   overrun     sticky: start seen while busy
module modulus_lut_accumulator
  import modulus_acc_pkg::*;
#(
  parameter int BIT_LEN         = 51,
  parameter int WORD_LEN        = BIT_LEN - 1,
  parameter int NUM_ELEMENTS    = 21,
  parameter int ACC_ELEMENTS    = 173,
  parameter int TERMS_PER_CYCLE = 16,
  parameter int SUM_LEN         = WORD_LEN + $clog2(ACC_ELEMENTS + 2)
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic                                                clear_err,
  input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]                base,
  input  logic [NUM_ELEMENTS-1:0][ACC_ELEMENTS-1:0][WORD_LEN-1:0] lut_datas,
  output logic                                                busy,
  output logic                                                done,
  output logic [NUM_ELEMENTS-1:0][SUM_LEN-1:0]                sums,
  output logic                                                overrun
);

  localparam int N_PASS = num_passes(ACC_ELEMENTS, TERMS_PER_CYCLE);
  localparam int PASS_W = (N_PASS > 1) ? $clog2(N_PASS) : 1;

  acc_state_e                               state;
  logic [PASS_W-1:0]                        pass;
  logic                                     load;
  logic                                     accum;
  logic                                     last_pass;
  logic [NUM_ELEMENTS-1:0][SUM_LEN-1:0]     acc_next;

  assign accum     = (state == ST_ACCUM);
  assign load      = start && !accum;
  assign last_pass = accum && (pass == PASS_W'(N_PASS - 1));

  // Per-column term selection and accumulation. Indices past the end of the
  // table (only in the final partial pass) contribute zero.
  for (genvar e = 0; e < NUM_ELEMENTS; e++) begin : g_col
    logic [TERMS_PER_CYCLE-1:0][WORD_LEN-1:0] terms;

    always_comb begin
      terms = '0;
      for (int k = 0; k < TERMS_PER_CYCLE; k++) begin
        int idx;
        idx = int'(pass) * TERMS_PER_CYCLE + k;
        if (idx < ACC_ELEMENTS) terms[k] = lut_datas[e][idx];
      end
    end

    modulus_acc_column #(
      .BIT_LEN        (BIT_LEN),
      .WORD_LEN       (WORD_LEN),
      .TERMS_PER_CYCLE(TERMS_PER_CYCLE),
      .SUM_LEN        (SUM_LEN)
    ) u_col (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .en      (accum),
      .base    (base[e]),
      .terms   (terms),
      .acc_next(acc_next[e])
    );
  end

  // Control: FSM, pass counter, status flags and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pass    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      sums    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_ACCUM;
            pass  <= '0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (last_pass) begin
            state <= ST_DONE;
            pass  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            sums  <= acc_next;
          end else begin
            pass <= pass + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A start while busy sets the flag even if clear_err is also high.
      if (accum && start) overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modulus_lut_accumulator.sv
module tb_modulus_lut_accumulator;

  localparam int NE  = 21;
  localparam int AE  = 173;
  localparam int WL  = 50;
  localparam int BL  = 51;
  localparam int SL  = 58;
  localparam int LAT = 12;   // done cycle relative to the start cycle

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clear_err = 1'b0;
  logic [NE-1:0][BL-1:0]         base = '0;
  logic [NE-1:0][AE-1:0][WL-1:0] lut = '0;
  logic [NE-1:0][AE-1:0][WL-1:0] snap = '0;
  logic busy, done, overrun;
  logic [NE-1:0][SL-1:0] sums;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_s  [NE];
  logic [63:0] prev_s [NE];

  always #5 clk = ~clk;

  modulus_lut_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear_err(clear_err),
    .base     (base),
    .lut_datas(lut),
    .busy     (busy),
    .done     (done),
    .sums     (sums),
    .overrun  (overrun)
  );

  // LUT words must not move while the block is accumulating.
  always @(posedge clk) begin
    if (start && !busy) snap <= lut;
    else if (busy) assert (lut == snap) else $error("lut_datas changed while busy");
  end

  // Reference: each sum is the base plus every LUT word of that element.
  function automatic void model();
    for (int e = 0; e < NE; e++) begin
      logic [63:0] s;
      s = 64'(base[e]);
      for (int i = 0; i < AE; i++) s = s + 64'(lut[e][i]);
      exp_s[e] = s;
    end
  endfunction

  task automatic fill_random();
    for (int e = 0; e < NE; e++) begin
      base[e] = BL'({$urandom(), $urandom()});
      for (int i = 0; i < AE; i++) lut[e][i] = WL'({$urandom(), $urandom()});
    end
  endtask

  // Pulse start for one cycle and wait (bounded) for done; lat = cycles
  // from the start cycle to the done cycle, -1 on timeout.
  task automatic run_one(output int lat);
    int c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
    lat = (done === 1'b1) ? c : -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
    tests++; if (sums !== '0) begin fails++; $display("FAIL reset_sums got nonzero want 0"); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_ones();
    for (int e = 0; e < NE; e++) begin
      base[e] = '0;
      for (int i = 0; i < AE; i++) lut[e][i] = WL'(1);
    end
    model();
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (busy !== (c >= 1 && c <= 11)) begin
        fails++; $display("FAIL ones_busy cycle %0d got %b want %b", c, busy, (c >= 1 && c <= 11));
      end
      tests++;
      if (done !== (c == LAT)) begin
        fails++; $display("FAIL ones_done cycle %0d got %b want %b", c, done, (c == LAT));
      end
      if (c == LAT) begin
        for (int e = 0; e < NE; e++) begin
          tests++;
          if (64'(sums[e]) !== 64'd173 || exp_s[e] !== 64'd173) begin
            fails++; $display("FAIL ones_sum e=%0d got %0d want 173", e, sums[e]);
          end
        end
      end
    end
  endtask

  task automatic test_max();
    int lat;
    logic [63:0] full;
    full = 64'd173 * ((64'd1 << 50) - 64'd1) + (64'd1 << 51) - 64'd1;
    for (int e = 0; e < NE; e++) begin
      base[e] = '1;
      for (int i = 0; i < AE; i++) lut[e][i] = '1;
    end
    model();
    @(negedge clk);
    run_one(lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL max_latency got %0d want %0d", lat, LAT); end
    for (int e = 0; e < NE; e++) begin
      tests++;
      if (64'(sums[e]) !== full || exp_s[e] !== full) begin
        fails++; $display("FAIL max_sum e=%0d got %h want %h", e, sums[e], full);
      end
    end
  endtask

  task automatic test_last_partial();
    int lat;
    lut = '0;
    for (int e = 0; e < NE; e++) begin
      base[e] = BL'(1000);
      lut[e][AE-1] = WL'(e + 1);
    end
    @(negedge clk);
    run_one(lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL partial_latency got %0d want %0d", lat, LAT); end
    for (int e = 0; e < NE; e++) begin
      tests++;
      if (64'(sums[e]) !== 64'(1001 + e)) begin
        fails++; $display("FAIL partial_sum e=%0d got %0d want %0d", e, sums[e], 1001 + e);
      end
    end
  endtask

  task automatic test_overrun();
    bit early_done;
    early_done = 1'b0;
    fill_random();
    model();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      start = 1'b0;
      clear_err = 1'b0;
      if (c < LAT && done !== 1'b0) early_done = 1'b1;
      if (c == 6) begin
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b want 1", overrun); end
      end
      if (c == 7) begin
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", overrun); end
      end
      if (c == 9) begin
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
      end
      if (c == 10) begin
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear2 got %b want 0", overrun); end
      end
      if (c == LAT) begin
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL ovr_done got %b want 1", done); end
        for (int e = 0; e < NE; e++) begin
          tests++;
          if (64'(sums[e]) !== exp_s[e]) begin
            fails++; $display("FAIL ovr_sum e=%0d got %h want %h", e, sums[e], exp_s[e]);
          end
        end
      end
      if (c == 5) start = 1'b1;
      if (c == 6) clear_err = 1'b1;
      if (c == 8) begin start = 1'b1; clear_err = 1'b1; end
      if (c == 9) clear_err = 1'b1;
    end
    tests++; if (early_done) begin fails++; $display("FAIL ovr_early_done got 1 want 0"); end
    clear_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit early_done;
    early_done = 1'b0;
    fill_random();
    model();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 2 * LAT; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c != LAT && c != 2 * LAT && done !== 1'b0) early_done = 1'b1;
      if (c == LAT) begin
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b want 1", done); end
        for (int e = 0; e < NE; e++) prev_s[e] = exp_s[e];
        fill_random();
        model();
        start = 1'b1;
      end
      if (c == LAT + 1 || c == 2 * LAT - 1) begin
        for (int e = 0; e < NE; e++) begin
          tests++;
          if (64'(sums[e]) !== prev_s[e]) begin
            fails++; $display("FAIL b2b_hold c=%0d e=%0d got %h want %h", c, e, sums[e], prev_s[e]);
          end
        end
      end
      if (c == 2 * LAT) begin
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done2 got %b want 1", done); end
        for (int e = 0; e < NE; e++) begin
          tests++;
          if (64'(sums[e]) !== exp_s[e]) begin
            fails++; $display("FAIL b2b_sum2 e=%0d got %h want %h", e, sums[e], exp_s[e]);
          end
        end
      end
    end
    tests++; if (early_done) begin fails++; $display("FAIL b2b_stray_done got 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit saw_done;
    saw_done = 1'b0;
    fill_random();
    model();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = (c == 3);
    end
    start = 1'b0;
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL rstmid_pre_overrun got %b want 1", overrun); end
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", done); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
    tests++; if (sums !== '0) begin fails++; $display("FAIL rstmid_sums got nonzero want 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    tests++; if (saw_done) begin fails++; $display("FAIL rstmid_resumed got activity want idle"); end
    run_one(lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); end
    for (int e = 0; e < NE; e++) begin
      tests++;
      if (64'(sums[e]) !== exp_s[e]) begin
        fails++; $display("FAIL rstmid_sum e=%0d got %h want %h", e, sums[e], exp_s[e]);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      fill_random();
      model();
      run_one(lat);
      tests++; if (lat !== LAT) begin fails++; $display("FAIL rand_latency n=%0d got %0d want %0d", n, lat, LAT); end
      for (int e = 0; e < NE; e++) begin
        tests++;
        if (64'(sums[e]) !== exp_s[e]) begin
          fails++; $display("FAIL rand_sum n=%0d e=%0d got %h want %h", n, e, sums[e], exp_s[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_max();
    test_last_partial();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
